// File: rtl/counter_arbiter.sv
// Round-robin arbiter that grants increments on a shared counter and stops
// issuing them once the counter reaches the terminal count.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | drive ctr_rst to zero the shared counter, no grants
//   RUN   | arbitrate requests, one increment per grant, watch the limit
//   FULL  | terminal count reached, requests ignored until clear
module counter_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [R-1:0] req,
    output logic [R-1:0] gnt,
    input  logic         clear,
    input  logic [N-1:0] limit,
    input  logic [N-1:0] count,
    output logic         incr,
    output logic         ctr_rst,
    output logic         full
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_nxt;
    logic [R-1:0]   gnt_nxt;
    logic [PW-1:0]  pick_idx;
    logic           pick_vld;
    logic [N:0]     pending;
    logic           at_limit;

    // The increment still in flight counts toward the limit, so back-to-back
    // grants never overshoot it.
    assign pending  = {1'b0, count} + {{N{1'b0}}, incr};
    assign at_limit = (pending >= {1'b0, limit});

    // Round-robin search starting at ptr; walking offsets from the far end
    // down lets the closest requester overwrite the others.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_w;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        idx_w    = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % R;
            idx_w = idx[PW-1:0];
            if (req[idx_w]) begin
                pick_vld = 1'b1;
                pick_idx = idx_w;
            end
        end
    end

    // Next-state, next-grant and next-pointer decision.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        ptr_nxt   = ptr;
        case (state)
            CLEAR: begin
                state_nxt = clear ? CLEAR : RUN;
            end
            RUN: begin
                if (clear) begin
                    state_nxt = CLEAR;
                end else if (at_limit) begin
                    state_nxt = FULL;
                end else if (pick_vld) begin
                    gnt_nxt[pick_idx] = 1'b1;
                    ptr_nxt = (pick_idx == PW'(R - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            FULL: begin
                if (clear) begin
                    state_nxt = CLEAR;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // State, pointer and all outputs registered; reset drops any grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= '0;
            gnt     <= '0;
            incr    <= 1'b0;
            ctr_rst <= 1'b1;
            full    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            incr    <= |gnt_nxt;
            ctr_rst <= (state_nxt == CLEAR);
            full    <= (state_nxt == FULL);
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: expected grants are queued as stimulus
// is applied and a negedge monitor pops and compares each grant it sees.
module tb_counter_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] limit;
    logic [7:0] count = 8'd0;
    logic       incr;
    logic       ctr_rst;
    logic       full;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    counter_arbiter #(.N(8), .R(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .clear   (clear),
        .limit   (limit),
        .count   (count),
        .incr    (incr),
        .ctr_rst (ctr_rst),
        .full    (full)
    );

    always #5 clk = ~clk;

    // Shared counter: reset dominates increment.
    always @(posedge clk) begin
        if (ctr_rst)   count <= 8'd0;
        else if (incr) count <= count + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    // Grant monitor.
    always @(negedge clk) begin
        check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (gnt != 4'b0000) begin
            if (exp_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
            else                   check("gnt_seq", 32'(gnt), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; req = 4'b0000; limit = 8'd10;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_incr", 32'(incr), 32'd0);
        check("rst_ctr_rst", 32'(ctr_rst), 32'd1);
        check("rst_full", 32'(full), 32'd0);

        // Continuous requests, limit 10.
        cyc(2);
        rst = 1'b0; req = 4'b1111;
        push4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        push4(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        cyc(1);
        check("first_gnt_latency", 32'(gnt), 32'd0);
        check("clear_cycle_done", 32'(ctr_rst), 32'd0);
        cyc(20);
        check("t1_full", 32'(full), 32'd1);
        check("t1_count", 32'(count), 32'd10);
        check("t1_incr", 32'(incr), 32'd0);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Clear pulse from FULL, then limit 3 with pointer wrap.
        req = 4'b0000; clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("t2_ctr_rst", 32'(ctr_rst), 32'd1);
        check("t2_full_drop", 32'(full), 32'd0);
        cyc(1);
        check("t2_count_zero", 32'(count), 32'd0);
        check("t2_ctr_rst_off", 32'(ctr_rst), 32'd0);
        limit = 8'd3; req = 4'b0100;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        cyc(1);
        req = 4'b0101;
        cyc(10);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd3);
        check("t2_incr", 32'(incr), 32'd0);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // limit 0: no grants, FULL after first RUN cycle, raising limit stays FULL.
        req = 4'b0000; clear = 1'b1;
        cyc(1);
        clear = 1'b0; limit = 8'd0; req = 4'b1111;
        cyc(1);
        check("t3_run_not_full", 32'(full), 32'd0);
        cyc(1);
        check("t3_full", 32'(full), 32'd1);
        limit = 8'd5;
        cyc(5);
        check("t3_full_held", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd0);
        check("t3_queue", 32'(exp_q.size()), 32'd0);

        // Clear coinciding with a grant decision keeps the pointer.
        req = 4'b0000; clear = 1'b1; limit = 8'd10;
        cyc(1);
        clear = 1'b0;
        cyc(1);
        req = 4'b0010; clear = 1'b1;
        cyc(1);
        check("t4_gnt_suppressed", 32'(gnt), 32'd0);
        check("t4_ctr_rst", 32'(ctr_rst), 32'd1);
        check("t4_incr", 32'(incr), 32'd0);
        clear = 1'b0; req = 4'b0110;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        cyc(3);
        req = 4'b0000;
        cyc(3);
        check("t4_count", 32'(count), 32'd2);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a grant cycle.
        req = 4'b1111;
        exp_q.push_back(4'b1000);
        cyc(1);
        #2 rst = 1'b1;
        #1;
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_incr", 32'(incr), 32'd0);
        check("t5_ctr_rst", 32'(ctr_rst), 32'd1);
        check("t5_full", 32'(full), 32'd0);
        cyc(2);
        limit = 8'd3;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        #3 rst = 1'b0;
        cyc(1);
        check("t5_first_gnt_latency", 32'(gnt), 32'd0);
        check("t5_count_zero", 32'(count), 32'd0);
        cyc(12);
        check("t5_full_end", 32'(full), 32'd1);
        check("t5_count_end", 32'(count), 32'd3);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter N, 8, width of the shared counter value and limit.
REQ-002 Parameter R, 4, number of requesters, 2 to 16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  R  per-requester increment request, level, held until granted.
REQ-006 gnt  output  R  one-hot grant, registered, high for exactly one cycle per granted increment.
REQ-007 clear  input  1  synchronous command to zero the shared counter.
REQ-008 limit  input  N  terminal count, sampled every cycle.
REQ-009 count  input  N  current value from the shared counter.
REQ-010 incr  output  1  increment strobe to the shared counter, registered.
REQ-011 ctr_rst  output  1  synchronous reset strobe to the shared counter, registered.
REQ-012 full  output  1  high while the controller is in state FULL.

Function
REQ-013 Shared counter contract: count updates at the rising edge that ends a cycle with incr=1 (count+1, wrapping mod 2^N) or ctr_rst=1 (0, dominant over incr); the new value is visible in the following cycle.
REQ-014 FSM states: CLEAR, RUN, FULL, encoded in 2 bits.
REQ-015 CLEAR: ctr_rst=1, incr=0, gnt=0; next state is always RUN after one cycle unless clear is sampled high again, in which case it stays in CLEAR.
REQ-016 RUN: at each edge, if clear=1 -> CLEAR; else if (count + incr) >= limit (N+1-bit compare) -> FULL; else if req!=0 -> issue one grant; else remain idle in RUN.
REQ-017 Grant latency: req sampled at edge k -> gnt[i]=1 and incr=1 in the cycle after edge k; both deassert after one cycle unless a new grant is issued.
REQ-018 Back-to-back grants: allowed on every cycle; the (count + incr) term prevents overshooting limit when an increment is still in flight.
REQ-019 Arbitration: round-robin; pointer p (log2 R bits, reset 0); search order p, p+1, ..., p+R-1 mod R; after granting i, p <= (i+1) mod R; p is unchanged when there is no grant.
REQ-020 gnt is zero or one-hot; popcount(gnt) <= 1 every cycle; gnt[i]=1 only if req[i] was 1 at the sampling edge.
REQ-021 FULL: full=1, gnt=0, incr=0; requests are ignored; exits only on clear=1 -> CLEAR.
REQ-022 limit=0: RUN transitions to FULL at the first edge with no grant issued.
REQ-023 clear has priority over requests in every state; a clear sampled in the same edge as a grant decision suppresses the grant.
REQ-024 An in-flight incr coinciding with ctr_rst is permitted; counter reset dominates (REQ-013).
REQ-025 A change in limit takes effect at the next edge; lowering limit below count in RUN -> FULL; raising limit in FULL does not exit FULL.
REQ-026 Outputs are all registered; no combinational path exists from any input to any output.

Reset
REQ-027 While rst=1: state=CLEAR, ctr_rst=1, incr=0, gnt=0, full=0, p=0, with all values taking effect immediately (asynchronously).
REQ-028 After rst deasserts: one CLEAR cycle (ctr_rst=1), then RUN; first grant no earlier than the second edge after release.
REQ-029 rst asserted mid-grant forces gnt=0 and incr=0 immediately; the granted increment counts as dropped.

Verification
REQ-030 N=8, R=4, limit=10, req=4'b1111 continuous after reset -> gnt sequence 0001,0010,0100,1000,0001,...; exactly 10 grants; count reaches 10; full=1; no grant thereafter.
REQ-031 limit=3, req[2] only, then req=4'b0101 -> grants: 0100, then 0001 (pointer at 3 wraps to 0), then 0100; full=1 with count=3 and no 4th incr.
REQ-032 In FULL with count=10, pulse clear for 1 cycle -> next cycle ctr_rst=1, full=0; count=0 the cycle after; grants resume.
REQ-033 clear=1 on the same edge where req=4'b0010 would be granted -> gnt stays 0, ctr_rst=1, and p is unchanged.
REQ-034 limit=0 after reset with req=4'b1111 -> zero grants; full=1 from the second cycle of RUN; then limit=5 -> full remains 1 until clear.
REQ-035 rst pulse during a grant cycle, asynchronous to clk -> gnt=0, incr=0, ctr_rst=1 before the next edge; after release, the arbitration order restarts at requester 0.
